// File: rtl/dac_frame_receiver.sv
// 3-wire serial frame receiver (CS/SCLK/DIN, MSB first), oversampled into the clk domain.
// Optional build macro RX_TIMEOUT_EN aborts a frame whose SCLK stalls while CS is low.
module dac_frame_receiver #(
    parameter int FRAME_BITS     = 16,
    parameter int SAMPLE_RISING  = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CS,
    input  logic                  SCLK,
    input  logic                  DIN,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_error,
    output logic                  busy
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t                state_r;
    logic                  cs_meta_r, cs_sync_r, cs_prev_r;
    logic                  sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic                  din_meta_r, din_sync_r, din_prev_r;
    logic                  cs_rise_r, cs_fall_r, samp_r, samp_s;
    logic [1:0]            settle_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic [CW-1:0]         cnt_r;
`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]         tmo_r;
`endif

    // Selects which SCLK transition counts as a sampling edge.
    always_comb begin
        samp_s = 1'b0;
        if (SAMPLE_RISING != 0) begin
            samp_s = sclk_sync_r & ~sclk_prev_r;
        end else begin
            samp_s = ~sclk_sync_r & sclk_prev_r;
        end
    end

    // Synchronizers, edge detectors and a settle counter so reset idle levels never look like pin edges.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            cs_prev_r   <= 1'b1;
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            din_meta_r  <= 1'b0;
            din_sync_r  <= 1'b0;
            din_prev_r  <= 1'b0;
            cs_rise_r   <= 1'b0;
            cs_fall_r   <= 1'b0;
            samp_r      <= 1'b0;
            settle_r    <= 2'd0;
        end else begin
            cs_meta_r   <= CS;
            cs_sync_r   <= cs_meta_r;
            cs_prev_r   <= cs_sync_r;
            sclk_meta_r <= SCLK;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            din_meta_r  <= DIN;
            din_sync_r  <= din_meta_r;
            din_prev_r  <= din_sync_r;
            cs_rise_r   <= cs_sync_r & ~cs_prev_r;
            cs_fall_r   <= ~cs_sync_r & cs_prev_r;
            samp_r      <= samp_s;
            if (settle_r != 2'd3) begin
                settle_r <= settle_r + 2'd1;
            end else begin
                settle_r <= settle_r;
            end
        end
    end

    // Frame state machine with registered strobes; a CS rise outranks a simultaneous SCLK edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_WAIT;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            busy     <= 1'b0;
            shift_r  <= '0;
            cnt_r    <= '0;
`ifdef RX_TIMEOUT_EN
            tmo_r    <= '0;
`endif
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            case (state_r)
                ST_WAIT: begin
                    if (cs_sync_r && (settle_r == 2'd3)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_IDLE: begin
                    if (cs_fall_r) begin
                        shift_r <= '0;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_SHIFT;
`ifdef RX_TIMEOUT_EN
                        tmo_r   <= '0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise_r) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                        if (cnt_r == CNT_FULL) begin
                            rx_data  <= shift_r;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                    end else if (samp_r) begin
                        shift_r <= {shift_r[FRAME_BITS-2:0], din_prev_r};
                        if (cnt_r != CNT_SAT) begin
                            cnt_r <= cnt_r + CW'(1);
                        end else begin
                            cnt_r <= cnt_r;
                        end
`ifdef RX_TIMEOUT_EN
                        tmo_r <= '0;
                    end else if (tmo_r == TMO_LAST) begin
                        rx_error <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= ST_WAIT;
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
`else
                    end else begin
                        state_r <= ST_SHIFT;
`endif
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_WAIT;
                end
            endcase
        end
    end

endmodule
